sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO that buffers data between a producer and a consumer.
//  Adds the following over the basic FIFO:
//   - occupancy count
//   - programmable almost_full and almost_empty flags
//   - overflow and underflow error pulses
//   - selectable standard or first-word-fall-through (FWFT) read mode
//  Sits on the same wr_en/rd_en/d_in/d_out/full/empty contract as the existing FIFO interface.
// PARAMETERS
//  WIDTH      8   data word width in bits (>=1)
//  DEPTH      16  number of entries; power of two, >=4
//  AF_THRESH  14  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
//  FWFT       0   0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk           in   1                     clock; all logic on posedge
//  rst           in   1                     synchronous reset, active-high
//  wr_en         in   1                     write request
//  rd_en         in   1                     read request
//  d_in          in   WIDTH                 write data
//  d_out         out  WIDTH                 read data
//  full          out  1                     count == DEPTH
//  empty         out  1                     count == 0
//  almost_full   out  1                     count >= AF_THRESH
//  almost_empty  out  1                     count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1       current occupancy, 0..DEPTH
//  overflow      out  1                     1-cycle pulse: write was rejected
//  underflow     out  1                     1-cycle pulse: read was rejected
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=0, underflow=0, d_out=0.
//    Reset takes effect mid-operation too: buffered data is discarded, storage array is not cleared.
//    rst overrides wr_en and rd_en in the same cycle.
//  - rd_acc = rd_en & ~empty.
//  - wr_acc = wr_en & (~full | rd_acc). Write while full is accepted only if a read pops the same cycle.
//  - Both accepted in one cycle: count unchanged, both pointers advance.
//  - Empty with wr_en & rd_en: write accepted, read rejected (underflow pulses).
//  - count_next = count + wr_acc - rd_acc.
//  - All flags are registered and derived from count_next. They reflect the state after the
//    same edge, with no extra cycle of lag.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. mem[wr_ptr] <= d_in on wr_acc.
//  - overflow  <= wr_en & ~wr_acc. Asserted for exactly the cycle after the rejected request.
//  - underflow <= rd_en & ~rd_acc. Asserted for exactly the cycle after the rejected request.
//    Neither flag is sticky. A rejected access changes no pointer, count or data.
//  - FWFT=0:
//     - d_out <= mem[rd_ptr] on rd_acc, so data appears 1 cycle after the accepted read edge.
//     - d_out holds its value otherwise, including while empty.
//  - FWFT=1:
//     - d_out = mem[rd_ptr] combinationally, so the head word is visible whenever empty=0.
//     - rd_acc pops the head word.
//     - A write into an empty FIFO makes the word visible and drops empty after that edge.
//     - d_out is don't-care while empty.
//  - Simultaneous read and write on a 1-entry FIFO:
//     - The old head is read.
//     - The new word becomes the head.
//     - count stays at 1.
//  - Parameter checks: elaboration $error if DEPTH is not a power of two or a threshold is out of range.
// TESTING (WIDTH=8, DEPTH=16, AF=14, AE=2 unless noted)
//  1. Reset: hold rst 2 cycles with wr_en=rd_en=1
//     -> count=0, empty=1, full=0, almost_empty=1, overflow=0, underflow=0, d_out=0.
//  2. Fill and drain: write 0x00..0x0F, then read 16 times.
//     -> almost_full rises after write #14; full rises after write #16.
//     -> Reads return 0x00..0x0F in order (FWFT=0: 1 cycle after each rd).
//     -> almost_empty rises when count hits 2; empty rises after read #16.
//  3. Overflow and underflow:
//     - Full FIFO, wr_en=1 alone -> overflow pulses 1 cycle; count stays 16; contents unchanged.
//     - Empty FIFO, rd_en=1 alone -> underflow pulses 1 cycle; count stays 0.
//  4. Simultaneous access:
//     - Full FIFO, wr_en=rd_en=1 with d_in=0xAA -> both accepted, count stays 16, no overflow;
//       0xAA is read last after draining.
//     - Empty FIFO, both asserted -> count=1, underflow=1.
//  5. Wrap-around: 40 random interleaved read/write cycles keeping count between 3 and 12
//     -> scoreboard order matches, pointers wrap, and count always equals writes minus reads.
//  6. FWFT=1: write 0x5C into empty
//     -> next cycle empty=0 and d_out=0x5C with no rd_en.
//     -> Assert rd_en -> empty=1 at the next edge.
//     -> Assert rst with count=7 -> count=0 and empty=1 at the next edge.

Source files
------------

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with occupancy count, almost-full and
//               almost-empty flags, overflow/underflow pulses, and a
//               standard or first-word-fall-through read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         d_in,
  output logic [WIDTH-1:0]         d_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_THRESH);

  // Configuration sanity checks, evaluated once at elaboration.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_flags: WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of two and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo_flags: FWFT must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [CW-1:0]    count_next;

  // Accept logic: a write into a full FIFO is only taken when a read frees a slot.
  always_comb begin
    rd_acc     = rd_en & ~empty;
    wr_acc     = wr_en & (~full | rd_acc);
    count_next = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
  end

  // Pointers, count and flags; flags come from count_next so they track the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count        <= count_next;
      full         <= (count_next == DEPTH_CNT);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_CNT);
      almost_empty <= (count_next <= AE_CNT);
      overflow     <= wr_en & ~wr_acc;
      underflow    <= rd_en & ~rd_acc;
    end
  end

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= d_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so no stale data leaks out.
      always_comb begin
        d_out = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_std
      // Registered read: data appears the cycle after an accepted read and holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          d_out <= '0;
        end else if (rd_acc) begin
          d_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flags
// Description : Scoreboard bench driving a standard-read and an FWFT instance
//               with identical stimulus against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] d_in = '0;

  logic [WIDTH-1:0] d_out0, d_out1;
  logic             full0, empty0, af0, ae0, ovf0, unf0;
  logic             full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]       count0, count1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in), .d_out(d_out0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in), .d_out(d_out1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    int         cnt;
    bit         full, empty, af, ae, ovf, unf;
    logic [7:0] d0;
    bit         d1_chk;
    logic [7:0] d1;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic [7:0] last_d0 = '0;
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_flags(input string tag, input logic [4:0] c, input logic f, input logic em,
                             input logic a_f, input logic a_e, input logic ov, input logic un,
                             input exp_t e);
    chk({tag, ".count"}, {27'b0, c}, e.cnt);
    chk({tag, ".full"}, {31'b0, f}, {31'b0, e.full});
    chk({tag, ".empty"}, {31'b0, em}, {31'b0, e.empty});
    chk({tag, ".almost_full"}, {31'b0, a_f}, {31'b0, e.af});
    chk({tag, ".almost_empty"}, {31'b0, a_e}, {31'b0, e.ae});
    chk({tag, ".overflow"}, {31'b0, ov}, {31'b0, e.ovf});
    chk({tag, ".underflow"}, {31'b0, un}, {31'b0, e.unf});
  endtask

  // One clock of stimulus: drive inputs, advance the reference model, queue expectations.
  task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] din);
    exp_t e;
    bit   racc;
    bit   wacc;
    @(negedge clk);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    d_in  = din;
    if (r) begin
      model_q.delete();
      last_d0 = '0;
      e.ovf   = 1'b0;
      e.unf   = 1'b0;
    end else begin
      racc = rd && (model_q.size() > 0);
      wacc = w && ((model_q.size() < DEPTH) || racc);
      if (racc) last_d0 = model_q.pop_front();
      if (wacc) model_q.push_back(din);
      e.ovf = w && !wacc;
      e.unf = rd && !racc;
    end
    e.cnt    = model_q.size();
    e.full   = (e.cnt == DEPTH);
    e.empty  = (e.cnt == 0);
    e.af     = (e.cnt >= AF);
    e.ae     = (e.cnt <= AE);
    e.d0     = last_d0;
    e.d1_chk = (e.cnt > 0);
    e.d1     = e.d1_chk ? model_q[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge, pop the expectation for that edge and compare both instances.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_flags("std", count0, full0, empty0, af0, ae0, ovf0, unf0, mon_e);
      check_flags("fwft", count1, full1, empty1, af1, ae1, ovf1, unf1, mon_e);
      chk("std.d_out", {24'b0, d_out0}, {24'b0, mon_e.d0});
      if (mon_e.d1_chk) chk("fwft.d_out", {24'b0, d_out1}, {24'b0, mon_e.d1});
    end
  end

  initial begin
    bit w;
    bit r;
    // Reset held two cycles with both requests active.
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    // Fill with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    // Write into full: overflow, contents unchanged.
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    // Simultaneous on full: both accepted, 0xAA lands at the tail.
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    // Drain everything.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    // Read from empty: underflow.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    // Both on empty, then both on a 1-entry FIFO.
    step(1'b0, 1'b1, 1'b1, 8'h33);
    step(1'b0, 1'b1, 1'b1, 8'h44);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    // Preload, then bounded interleaving between 3 and 12 entries.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (model_q.size() >= 12) w = 1'b0;
      if (model_q.size() <= 3)  r = 1'b0;
      step(1'b0, w, r, 8'($urandom));
    end
    // Write-heavy then read-heavy random traffic to hit full/empty boundaries.
    for (int i = 0; i < 120; i++) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) == 0);
      step(1'b0, w, r, 8'($urandom));
    end
    for (int i = 0; i < 120; i++) begin
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      step(1'b0, w, r, 8'($urandom));
    end
    // Fall-through scenario: single word, idle, pop.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h5C);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    // Mid-operation reset with seven entries buffered.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h7E);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    // Let the monitor consume the remaining expectations, within a fixed bound.
    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
